// File: rtl/traffic_phase_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// traffic_phase_sequencer_pkg
// Shared definitions for the two-road intersection controller: state codes,
// lamp encodings ({R,Y,G} one-hot) and the direction constants used by the
// next-direction register.
// No ports (package).
// ---------------------------------------------------------------------------
package traffic_phase_sequencer_pkg;

    // State codes double as the debug phase output, so the values are fixed.
    // Code 7 is unused; the FSM treats it as a request to recover to ALL_RED.
    typedef enum logic [2:0] {
        ST_ALL_RED  = 3'd0,
        ST_NS_GRN   = 3'd1,
        ST_NS_YEL   = 3'd2,
        ST_EW_GRN   = 3'd3,
        ST_EW_YEL   = 3'd4,
        ST_PED_WALK = 3'd5,
        ST_NIGHT    = 3'd6
    } state_t;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    localparam logic DIR_NS = 1'b0;
    localparam logic DIR_EW = 1'b1;

    function automatic logic is_green(input state_t s);
        return (s == ST_NS_GRN) || (s == ST_EW_GRN);
    endfunction

endpackage

// File: rtl/traffic_phase_sequencer_if.sv
// ---------------------------------------------------------------------------
// traffic_phase_sequencer_if
// Groups the controller's functional I/O.
//   tick       : 1-cycle timebase strobe (master -> slave)
//   ped_req    : debounced pedestrian button pulse (master -> slave)
//   night_mode : level request for flashing mode (master -> slave)
//   ns_light   : NS lamps {R,Y,G} (slave -> master)
//   ew_light   : EW lamps {R,Y,G} (slave -> master)
//   walk       : pedestrian walk lamp (slave -> master)
//   ped_ack    : registered echo of ped_req (slave -> master)
//   phase      : current state code (slave -> master)
// The controller connects through the slave modport; whoever drives the
// strobes and watches the lamps uses the master modport.
// ---------------------------------------------------------------------------
interface traffic_phase_sequencer_if;
    logic       tick;
    logic       ped_req;
    logic       night_mode;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic       walk;
    logic       ped_ack;
    logic [2:0] phase;

    modport master (
        output tick, ped_req, night_mode,
        input  ns_light, ew_light, walk, ped_ack, phase
    );

    modport slave (
        input  tick, ped_req, night_mode,
        output ns_light, ew_light, walk, ped_ack, phase
    );
endinterface

// File: rtl/traffic_phase_sequencer_timer.sv
// ---------------------------------------------------------------------------
// traffic_phase_sequencer_timer
// Phase timer: counts tick pulses since the last clear. o_done flags the tick
// that completes the phase (count already at the last value), so the FSM can
// leave the state on the same clock edge that samples that tick.
//   clk     : system clock
//   rst     : synchronous active-low reset
//   i_clr   : clear the count (asserted on every state entry)
//   i_tick  : timebase strobe
//   i_last  : last count value of the phase (phase length - 1)
//   o_done  : combinational, i_tick and count == i_last
// ---------------------------------------------------------------------------
module traffic_phase_sequencer_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_tick,
    input  logic [CNT_W-1:0] i_last,
    output logic             o_done
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_tick) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_done = i_tick && (r_cnt == i_last);

endmodule

// File: rtl/traffic_phase_sequencer.sv
// ---------------------------------------------------------------------------
// traffic_phase_sequencer
// Two-road (NS/EW) intersection controller. Cycles green/yellow/all-red,
// inserts a pedestrian walk phase on request and enters a flashing night
// mode. All time is measured in tick pulses; lamps are decoded from
// registered state only, so there is no input-to-output combinational path.
//   clk     : system clock
//   rst     : synchronous active-low reset
//   bus     : slave side of traffic_phase_sequencer_if
//             (tick, ped_req, night_mode in; ns_light, ew_light, walk,
//              ped_ack, phase out)
// Parameters: T_GREEN/T_YELLOW/T_ALLRED/T_WALK ticks per phase (each in
// 1..2**CNT_W), CNT_W phase counter width.
// ---------------------------------------------------------------------------
module traffic_phase_sequencer
    import traffic_phase_sequencer_pkg::*;
#(
    parameter int T_GREEN  = 6,
    parameter int T_YELLOW = 3,
    parameter int T_ALLRED = 1,
    parameter int T_WALK   = 4,
    parameter int CNT_W    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    traffic_phase_sequencer_if.slave  bus
);

    localparam logic [CNT_W-1:0] LAST_GREEN  = CNT_W'(T_GREEN  - 1);
    localparam logic [CNT_W-1:0] LAST_YELLOW = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] LAST_ALLRED = CNT_W'(T_ALLRED - 1);
    localparam logic [CNT_W-1:0] LAST_WALK   = CNT_W'(T_WALK   - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_next_dir;
    logic             r_flash;
    logic             r_ped_pending;
    logic             r_ped_ack;
    logic [CNT_W-1:0] w_last;
    logic             w_done;
    logic             w_clr;
    logic             w_entering;
    logic [2:0]       w_ns;
    logic [2:0]       w_ew;
    logic             w_walk;

    // Night mode ignores the counter, so it is held clear there to keep it
    // from free-running.
    assign w_entering = (w_state_nxt != r_state);
    assign w_clr      = w_entering || (r_state == ST_NIGHT);

    traffic_phase_sequencer_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_clr),
        .i_tick (bus.tick),
        .i_last (w_last),
        .o_done (w_done)
    );

    // Phase length lookup, kept separate from the next-state logic so the
    // timer's done flag does not feed back into the block that selects it.
    always_comb begin
        w_last = LAST_ALLRED;
        case (r_state)
            ST_NS_GRN, ST_EW_GRN:  w_last = LAST_GREEN;
            ST_NS_YEL, ST_EW_YEL:  w_last = LAST_YELLOW;
            ST_PED_WALK:           w_last = LAST_WALK;
            ST_NIGHT:              w_last = '0;
            default:               w_last = LAST_ALLRED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_ALL_RED;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ALL_RED: begin
                if (w_done) begin
                    if (bus.night_mode) begin
                        w_state_nxt = ST_NIGHT;
                    end else if (r_ped_pending) begin
                        w_state_nxt = ST_PED_WALK;
                    end else begin
                        w_state_nxt = (r_next_dir == DIR_NS) ? ST_NS_GRN : ST_EW_GRN;
                    end
                end
            end
            ST_NS_GRN:   if (w_done) w_state_nxt = ST_NS_YEL;
            ST_NS_YEL:   if (w_done) w_state_nxt = ST_ALL_RED;
            ST_EW_GRN:   if (w_done) w_state_nxt = ST_EW_YEL;
            ST_EW_YEL:   if (w_done) w_state_nxt = ST_ALL_RED;
            ST_PED_WALK: begin
                // Walk already has both roads red, so go straight to green.
                if (w_done) begin
                    w_state_nxt = (r_next_dir == DIR_NS) ? ST_NS_GRN : ST_EW_GRN;
                end
            end
            ST_NIGHT: begin
                if (bus.tick && !bus.night_mode) w_state_nxt = ST_ALL_RED;
            end
            default:     w_state_nxt = ST_ALL_RED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_next_dir    <= DIR_NS;
            r_flash       <= 1'b0;
            r_ped_pending <= 1'b0;
            r_ped_ack     <= 1'b0;
        end else begin
            r_ped_ack <= bus.ped_req;

            // Entering walk consumes the request; a press on that same edge
            // is treated as already served.
            if (w_entering && (w_state_nxt == ST_PED_WALK)) begin
                r_ped_pending <= 1'b0;
            end else if (bus.ped_req) begin
                r_ped_pending <= 1'b1;
            end

            // Leaving night always restarts the day cycle on NS.
            if (w_entering && is_green(w_state_nxt)) begin
                r_next_dir <= ~r_next_dir;
            end else if ((r_state == ST_NIGHT) && w_entering) begin
                r_next_dir <= DIR_NS;
            end

            if (w_entering && (w_state_nxt == ST_NIGHT)) begin
                r_flash <= 1'b1;
            end else if ((r_state == ST_NIGHT) && bus.tick) begin
                r_flash <= ~r_flash;
            end
        end
    end

    always_comb begin
        w_ns   = LAMP_RED;
        w_ew   = LAMP_RED;
        w_walk = 1'b0;
        case (r_state)
            ST_NS_GRN:   w_ns = LAMP_GRN;
            ST_NS_YEL:   w_ns = LAMP_YEL;
            ST_EW_GRN:   w_ew = LAMP_GRN;
            ST_EW_YEL:   w_ew = LAMP_YEL;
            ST_PED_WALK: w_walk = 1'b1;
            ST_NIGHT: begin
                w_ns = r_flash ? LAMP_YEL : LAMP_OFF;
                w_ew = r_flash ? LAMP_RED : LAMP_OFF;
            end
            default: begin
                w_ns = LAMP_RED;
                w_ew = LAMP_RED;
            end
        endcase
    end

    assign bus.ns_light = w_ns;
    assign bus.ew_light = w_ew;
    assign bus.walk     = w_walk;
    assign bus.ped_ack  = r_ped_ack;
    assign bus.phase    = r_state;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
module tb_traffic_phase_sequencer;

    localparam int T_GREEN  = 6;
    localparam int T_YELLOW = 3;
    localparam int T_ALLRED = 1;
    localparam int T_WALK   = 4;

    typedef struct packed {
        logic [2:0] ph;
        logic [2:0] ns;
        logic [2:0] ew;
        logic       walk;
        logic       ack;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    traffic_phase_sequencer_if bus();

    traffic_phase_sequencer #(
        .T_GREEN  (T_GREEN),
        .T_YELLOW (T_YELLOW),
        .T_ALLRED (T_ALLRED),
        .T_WALK   (T_WALK),
        .CNT_W    (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    exp_t sb[$];

    // Reference model state (remaining-ticks style)
    int   m_st;
    int   m_rem;
    logic m_dir;
    logic m_flash;
    logic m_pend;
    logic m_ack;

    logic [2:0] obs_ph;
    logic [2:0] obs_ns;
    logic [2:0] obs_ew;
    logic       obs_walk;
    logic       obs_ack;

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    function automatic int dur(input int s);
        case (s)
            1, 3:    return T_GREEN;
            2, 4:    return T_YELLOW;
            5:       return T_WALK;
            default: return T_ALLRED;
        endcase
    endfunction

    function automatic exp_t expect_out(input int s, input logic fl, input logic ack);
        exp_t e;
        e.ph   = 3'(s);
        e.ns   = 3'b100;
        e.ew   = 3'b100;
        e.walk = (s == 5);
        e.ack  = ack;
        case (s)
            1: e.ns = 3'b001;
            2: e.ns = 3'b010;
            3: e.ew = 3'b001;
            4: e.ew = 3'b010;
            6: begin
                e.ns = fl ? 3'b010 : 3'b000;
                e.ew = fl ? 3'b100 : 3'b000;
            end
            default: ;
        endcase
        return e;
    endfunction

    task automatic model(input logic t, input logic p, input logic n, input logic r);
        int nx;
        if (!r) begin
            m_st = 0; m_rem = T_ALLRED; m_dir = 1'b0;
            m_flash = 1'b0; m_pend = 1'b0; m_ack = 1'b0;
            return;
        end
        nx = m_st;
        if (m_st == 6) begin
            if (t) begin
                if (!n) nx = 0;
                else    m_flash = ~m_flash;
            end
        end else if (t) begin
            if (m_rem == 1) begin
                case (m_st)
                    0:       nx = n ? 6 : (m_pend ? 5 : (m_dir ? 3 : 1));
                    1:       nx = 2;
                    3:       nx = 4;
                    5:       nx = m_dir ? 3 : 1;
                    default: nx = 0;
                endcase
            end else begin
                m_rem--;
            end
        end
        if (nx != m_st) begin
            if (m_st == 6) m_dir = 1'b0;
            if (nx == 1 || nx == 3) m_dir = ~m_dir;
            if (nx == 6) m_flash = 1'b1;
            m_rem = dur(nx);
        end
        if (nx == 5 && m_st != 5) m_pend = 1'b0;
        else if (p)               m_pend = 1'b1;
        m_ack = p;
        m_st  = nx;
    endtask

    // One clock: drive inputs, push model expectation, sample #1 after edge.
    task automatic cyc(input logic t, input logic p, input logic n, input logic r);
        exp_t e;
        rst            = r;
        bus.tick       = t;
        bus.ped_req    = p;
        bus.night_mode = n;
        model(t, p, n, r);
        sb.push_back(expect_out(m_st, m_flash, m_ack));
        @(posedge clk);
        #1;
        obs_ph   = bus.phase;
        obs_ns   = bus.ns_light;
        obs_ew   = bus.ew_light;
        obs_walk = bus.walk;
        obs_ack  = bus.ped_ack;
        e = sb.pop_front();
        chk("sb_phase", obs_ph, e.ph);
        chk("sb_ns", obs_ns, e.ns);
        chk("sb_ew", obs_ew, e.ew);
        chk("sb_walk", {2'b00, obs_walk}, {2'b00, e.walk});
        chk("sb_ack", {2'b00, obs_ack}, {2'b00, e.ack});
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // Run with tick every cycle until the phase reaches target; the final
    // comparison also flags an expired budget.
    task automatic wait_ph(input int target, input logic n, input int budget, input string tag);
        int k;
        k = 0;
        while (obs_ph != 3'(target) && k < budget) begin
            cyc(1'b1, 1'b0, n, 1'b1);
            k++;
        end
        chk(tag, obs_ph, 3'(target));
    endtask

    task automatic check_day_sequence(input string tag);
        int seq_st[6];
        int seq_len[6];
        seq_st  = '{1, 2, 0, 3, 4, 0};
        seq_len = '{T_GREEN, T_YELLOW, T_ALLRED, T_GREEN, T_YELLOW, T_ALLRED};
        for (int rep = 0; rep < 2; rep++) begin
            for (int s = 0; s < 6; s++) begin
                for (int c = 0; c < seq_len[s]; c++) begin
                    cyc(1'b1, 1'b0, 1'b0, 1'b1);
                    chk(tag, obs_ph, 3'(seq_st[s]));
                end
            end
        end
    endtask

    initial begin
        int walks;
        int grn;
        bus.tick = 1'b0; bus.ped_req = 1'b0; bus.night_mode = 1'b0;
        obs_ph = 3'd0;

        // 1: reset values and plain day cycle
        do_reset();
        chk("rst_ns", obs_ns, 3'b100);
        chk("rst_ew", obs_ew, 3'b100);
        chk("rst_phase", obs_ph, 3'd0);
        check_day_sequence("t1_seq");

        // 2: pedestrian request during NS_GRN
        do_reset();
        wait_ph(1, 1'b0, 4, "t2_ns_grn");
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        chk("t2_ack_hi", {2'b00, obs_ack}, 3'd1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        chk("t2_ack_lo", {2'b00, obs_ack}, 3'd0);
        walks = 0;
        while (obs_ph != 3'd5 && walks < 20) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b1);
            walks++;
        end
        walks = 0;
        for (int i = 0; i < 8; i++) begin
            if (obs_walk) walks++;
            if (obs_walk) chk("t2_walk_ns", obs_ns, 3'b100);
            if (obs_walk) chk("t2_walk_ew", obs_ew, 3'b100);
            if (obs_ph == 3'd5) cyc(1'b1, 1'b0, 1'b0, 1'b1);
        end
        chk("t2_walk_cnt", 3'(walks), 3'(T_WALK));
        chk("t2_after_walk", obs_ph, 3'd3);

        // 3: request absorbed on walk entry; request during walk stays pending
        do_reset();
        wait_ph(1, 1'b0, 4, "t3_ns_grn");
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        wait_ph(0, 1'b0, 20, "t3_allred");
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        chk("t3_enter_walk", obs_ph, 3'd5);
        wait_ph(0, 1'b0, 30, "t3_allred2");
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        chk("t3_absorb", obs_ph, 3'd1);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        wait_ph(0, 1'b0, 20, "t3_allred3");
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        chk("t3_walk_again", obs_ph, 3'd5);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        wait_ph(0, 1'b0, 30, "t3_allred4");
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        chk("t3_ped_in_walk", obs_ph, 3'd5);

        // 4: night mode raised mid-EW_GRN
        do_reset();
        wait_ph(3, 1'b0, 20, "t4_ew_grn");
        cyc(1'b1, 1'b0, 1'b1, 1'b1);
        chk("t4_no_preempt", obs_ph, 3'd3);
        wait_ph(4, 1'b1, 10, "t4_ew_yel");
        wait_ph(0, 1'b1, 10, "t4_allred");
        cyc(1'b1, 1'b0, 1'b1, 1'b1);
        chk("t4_night", obs_ph, 3'd6);
        for (int i = 0; i < 4; i++) begin
            chk("t4_flash_ns", obs_ns, (i % 2 == 0) ? 3'b010 : 3'b000);
            chk("t4_flash_ew", obs_ew, (i % 2 == 0) ? 3'b100 : 3'b000);
            cyc(1'b1, 1'b0, 1'b1, 1'b1);
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        chk("t4_exit_allred", obs_ph, 3'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        chk("t4_exit_ns", obs_ph, 3'd1);
        // Night after an NS green: next_dir would be EW, but exit forces NS
        cyc(1'b1, 1'b0, 1'b1, 1'b1);
        wait_ph(6, 1'b1, 20, "t4b_night");
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        chk("t4b_forced_ns", obs_ph, 3'd1);

        // 5: reset mid NS_YEL
        do_reset();
        wait_ph(2, 1'b0, 10, "t5_ns_yel");
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("t5_rst_phase", obs_ph, 3'd0);
        chk("t5_rst_ns", obs_ns, 3'b100);
        chk("t5_rst_ew", obs_ew, 3'b100);
        check_day_sequence("t5_seq");

        // 6: sparse ticks, every 5th cycle
        do_reset();
        grn = 0;
        for (int k = 0; k < 80; k++) begin
            cyc((k % 5) == 4, 1'b0, 1'b0, 1'b1);
            if (obs_ph == 3'd1) begin
                grn++;
                chk("t6_stable_ns", obs_ns, 3'b001);
            end
        end
        chk("t6_grn_cycles", 3'(grn / 5), 3'(T_GREEN));
        chk("t6_grn_exact", 3'(grn % 5), 3'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
